// File: rtl/register.sv
// GPIO register file: 8 word slots, byte-enabled writes, W1C pin-change status, 2-flop pin sync.
// Latency: reads 1 cycle (registered rdata), writes visible on rf_* the cycle after the edge; no backpressure.
module register (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:2]  addr,
    input  logic [3:0]  wben,
    input  logic        r_wn,
    input  logic [31:0] wdata,
    input  logic [15:0] ro_gpio_pinstate,
    output logic [31:0] rdata,
    output logic [15:0] rf_gpio_tristate,
    output logic [15:0] rf_gpio_datareg,
    output logic [15:0] rf_gpio_interrupt_mask
);

    localparam logic [2:0] A_TRISTATE = 3'd0;
    localparam logic [2:0] A_DATAREG  = 3'd1;
    localparam logic [2:0] A_PINSTATE = 3'd2;
    localparam logic [2:0] A_IMASK    = 3'd3;
    localparam logic [2:0] A_ISTATUS  = 3'd4;
    localparam logic [2:0] A_ID       = 3'd5;
    localparam logic [31:0] ID_VALUE  = 32'h4750_494F;

    logic [15:0] tristate_q, tristate_d;
    logic [15:0] datareg_q, datareg_d;
    logic [15:0] imask_q, imask_d;
    logic [15:0] istatus_q, istatus_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] sync1_q, sync1_d;
    logic [15:0] sync2_q, sync2_d;
    logic [15:0] sync3_q, sync3_d;
    logic [2:0]  prime_q, prime_d;

    logic [15:0] byte_mask;
    logic [15:0] wr_val;
    logic [15:0] set_bits;
    logic [15:0] clr_bits;
    logic [31:0] rd_val;
    logic [2:0]  slot;

    always_comb begin
        slot      = addr;
        byte_mask = {{8{wben[1]}}, {8{wben[0]}}};
        wr_val    = wdata[15:0] & byte_mask;

        tristate_d = tristate_q;
        datareg_d  = datareg_q;
        imask_d    = imask_q;
        clr_bits   = 16'h0000;

        if (!r_wn) begin
            case (slot)
                A_TRISTATE: tristate_d = (tristate_q & ~byte_mask) | wr_val;
                A_DATAREG:  datareg_d  = (datareg_q  & ~byte_mask) | wr_val;
                A_IMASK:    imask_d    = (imask_q    & ~byte_mask) | wr_val;
                A_ISTATUS:  clr_bits   = wr_val;
                default:    ;
            endcase
        end

        // The delayed copy is meaningless until three samples exist since reset.
        set_bits  = prime_q[2] ? (sync2_q ^ sync3_q) : 16'h0000;
        istatus_d = (istatus_q & ~clr_bits) | set_bits;

        sync1_d = ro_gpio_pinstate;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        prime_d = {prime_q[1:0], 1'b1};

        case (slot)
            A_TRISTATE: rd_val = {16'h0000, tristate_q};
            A_DATAREG:  rd_val = {16'h0000, datareg_q};
            A_PINSTATE: rd_val = {16'h0000, sync2_q};
            A_IMASK:    rd_val = {16'h0000, imask_q};
            A_ISTATUS:  rd_val = {16'h0000, istatus_q};
            A_ID:       rd_val = ID_VALUE;
            default:    rd_val = 32'h0000_0000;
        endcase
        rdata_d = r_wn ? rd_val : rdata_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tristate_q <= 16'h0000;
            datareg_q  <= 16'h0000;
            imask_q    <= 16'h0000;
            istatus_q  <= 16'h0000;
            rdata_q    <= 32'h0000_0000;
            sync1_q    <= 16'h0000;
            sync2_q    <= 16'h0000;
            sync3_q    <= 16'h0000;
            prime_q    <= 3'b000;
        end else begin
            tristate_q <= tristate_d;
            datareg_q  <= datareg_d;
            imask_q    <= imask_d;
            istatus_q  <= istatus_d;
            rdata_q    <= rdata_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
            prime_q    <= prime_d;
        end
    end

    assign rdata                  = rdata_q;
    assign rf_gpio_tristate       = tristate_q;
    assign rf_gpio_datareg        = datareg_q;
    assign rf_gpio_interrupt_mask = imask_q;

endmodule

// File: tb/tb_register.sv
// Directed and randomized checks of the GPIO register file against a sample-history model.
module tb_register;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [3:0]  wben = 4'd0;
    logic        r_wn = 1'b1;
    logic [31:0] wdata = 32'd0;
    logic [15:0] ro_gpio_pinstate = 16'd0;
    logic [31:0] rdata;
    logic [15:0] rf_gpio_tristate;
    logic [15:0] rf_gpio_datareg;
    logic [15:0] rf_gpio_interrupt_mask;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_tri, m_dat, m_imask, m_ist;
    logic [31:0] m_rdata;
    int          e;
    logic [15:0] samp [0:4095];

    register dut (
        .clock                  (clock),
        .reset                  (reset),
        .addr                   (addr),
        .wben                   (wben),
        .r_wn                   (r_wn),
        .wdata                  (wdata),
        .ro_gpio_pinstate       (ro_gpio_pinstate),
        .rdata                  (rdata),
        .rf_gpio_tristate       (rf_gpio_tristate),
        .rf_gpio_datareg        (rf_gpio_datareg),
        .rf_gpio_interrupt_mask (rf_gpio_interrupt_mask)
    );

    always #5 clock = ~clock;

    // Pin level sampled on edge k since reset; nothing sampled yet reads as 0.
    function automatic logic [15:0] get(input int k);
        if (k < 1) return 16'h0000;
        return samp[k];
    endfunction

    function automatic logic [31:0] rd_model(input logic [2:0] a, input logic [15:0] pins);
        case (a)
            3'd0:    return {16'h0000, m_tri};
            3'd1:    return {16'h0000, m_dat};
            3'd2:    return {16'h0000, pins};
            3'd3:    return {16'h0000, m_imask};
            3'd4:    return {16'h0000, m_ist};
            3'd5:    return 32'h4750_494F;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rdata"}, rdata, m_rdata);
        check({tag, ".tri"},   {16'h0, rf_gpio_tristate},       {16'h0, m_tri});
        check({tag, ".dat"},   {16'h0, rf_gpio_datareg},        {16'h0, m_dat});
        check({tag, ".imask"}, {16'h0, rf_gpio_interrupt_mask}, {16'h0, m_imask});
    endtask

    task automatic model_reset();
        m_tri = 0; m_dat = 0; m_imask = 0; m_ist = 0; m_rdata = 0; e = 0;
    endtask

    // One clock edge with the inputs already driven; returns at the following negedge.
    task automatic step(input string tag);
        logic [15:0] m, set, clr;
        @(posedge clock);
        e++;
        m   = {{8{wben[1]}}, {8{wben[0]}}};
        set = (e >= 4) ? (get(e-2) ^ get(e-3)) : 16'h0000;
        clr = 16'h0000;
        if (r_wn) m_rdata = rd_model(addr, get(e-2));
        else begin
            case (addr)
                3'd0: m_tri   = (m_tri   & ~m) | (wdata[15:0] & m);
                3'd1: m_dat   = (m_dat   & ~m) | (wdata[15:0] & m);
                3'd3: m_imask = (m_imask & ~m) | (wdata[15:0] & m);
                3'd4: clr     = wdata[15:0] & m;
                default: ;
            endcase
        end
        m_ist = (m_ist & ~clr) | set;
        samp[e] = ro_gpio_pinstate;
        @(negedge clock);
        check_all(tag);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] wb);
        addr = a; wdata = d; wben = wb; r_wn = 1'b0;
        step("wr");
    endtask

    task automatic rd(input logic [2:0] a);
        addr = a; r_wn = 1'b1; wben = 4'($urandom); wdata = $urandom;
        step("rd");
    endtask

    initial begin
        // Reset held 50 ns with random inputs.
        model_reset();
        for (int i = 0; i < 5; i++) begin
            addr = 3'($urandom); wben = 4'($urandom); r_wn = 1'($urandom);
            wdata = $urandom; ro_gpio_pinstate = 16'($urandom);
            #10;
        end
        @(negedge clock);
        check("rst.rdata", rdata, 32'h0);
        check("rst.tri", {16'h0, rf_gpio_tristate}, 32'h0);
        check("rst.dat", {16'h0, rf_gpio_datareg}, 32'h0);
        check("rst.imask", {16'h0, rf_gpio_interrupt_mask}, 32'h0);
        reset = 1'b1;

        // Stable non-zero pins across reset release must not flag anything.
        rd(3'd4); rd(3'd4); rd(3'd4); rd(3'd4); rd(3'd4); rd(3'd4);
        check("no_rst_edge", rdata, 32'h0);

        wr(3'd1, 32'hFFFF_A5C3, 4'b0001);
        check("be.dat", {16'h0, rf_gpio_datareg}, 32'h0000_00C3);
        rd(3'd1);
        check("be.rd", rdata, 32'h0000_00C3);
        wr(3'd1, 32'h0000_7E00, 4'b1110);
        wr(3'd1, 32'h1111_2222, 4'b0000);
        check("be.wben0", {16'h0, rf_gpio_datareg}, 32'h0000_7EC3);

        wr(3'd0, 32'h0000_1234, 4'b1111);
        wr(3'd3, 32'h0000_00FF, 4'b1111);
        check("full.tri", {16'h0, rf_gpio_tristate}, 32'h0000_1234);
        check("full.imask", {16'h0, rf_gpio_interrupt_mask}, 32'h0000_00FF);
        rd(3'd0);
        check("full.rd0", rdata, 32'h0000_1234);
        rd(3'd3);
        check("full.rd3", rdata, 32'h0000_00FF);
        wr(3'd2, 32'hDEAD_BEEF, 4'b1111);
        check("hold.rdata", rdata, 32'h0000_00FF);

        // Quiet the pins and clear whatever the step to 0 flagged.
        ro_gpio_pinstate = 16'h0000;
        rd(3'd0); rd(3'd0); rd(3'd0); rd(3'd0);
        wr(3'd4, 32'h0000_FFFF, 4'b0011);
        rd(3'd4);
        check("ist.clear", rdata, 32'h0);

        ro_gpio_pinstate = 16'h8001;
        rd(3'd0); rd(3'd0); rd(3'd2);
        check("sync.pin", rdata, 32'h0000_8001);
        rd(3'd4);
        check("sync.ist", rdata, 32'h0000_8001);
        rd(3'd4);
        check("ist.noclr_on_rd", rdata, 32'h0000_8001);

        wr(3'd4, 32'h0000_0001, 4'b0001);
        rd(3'd4);
        check("w1c", rdata, 32'h0000_8000);

        // Bit-0 change lands on the same edge as its W1C clear.
        ro_gpio_pinstate = 16'h8000;
        rd(3'd0); rd(3'd0);
        wr(3'd4, 32'h0000_0001, 4'b0011);
        rd(3'd4);
        check("w1c.race", rdata, 32'h0000_8001);

        rd(3'd5);
        check("id", rdata, 32'h4750_494F);
        wr(3'd2, 32'hFFFF_FFFF, 4'b1111);
        wr(3'd5, 32'hFFFF_FFFF, 4'b1111);
        wr(3'd6, 32'hFFFF_FFFF, 4'b1111);
        wr(3'd7, 32'hFFFF_FFFF, 4'b1111);
        check("ro.tri", {16'h0, rf_gpio_tristate}, 32'h0000_1234);
        rd(3'd7);
        check("rsv7", rdata, 32'h0);
        rd(3'd5);
        check("id2", rdata, 32'h4750_494F);
        rd(3'd6);
        check("rsv6", rdata, 32'h0);

        // Reset in the middle of a pending write aborts it.
        addr = 3'd0; wdata = 32'h0000_BEEF; wben = 4'b1111; r_wn = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("mid.tri", {16'h0, rf_gpio_tristate}, 32'h0);
        check("mid.dat", {16'h0, rf_gpio_datareg}, 32'h0);
        check("mid.rdata", rdata, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        wr(3'd0, 32'h0000_5A5A, 4'b0011);
        check("first_wr", {16'h0, rf_gpio_tristate}, 32'h0000_5A5A);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) ro_gpio_pinstate = 16'($urandom);
            addr  = 3'($urandom);
            wben  = 4'($urandom);
            r_wn  = 1'($urandom);
            wdata = $urandom;
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register.md
REGISTER -- requirements
Module: register

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clock  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous active-low reset; 0 = in reset.
REQ-004 addr  input  [4:2]  word address selecting one of 8 register slots.
REQ-005 wben  input  4  byte write enables; bit n enables wdata[8n+7:8n].
REQ-006 r_wn  input  1  access direction; 1 = read, 0 = write.
REQ-007 wdata  input  32  write data.
REQ-008 ro_gpio_pinstate  input  16  raw GPIO pin levels; asynchronous to clock.
REQ-009 rdata  output  32  read data.
REQ-010 rf_gpio_tristate  output  16  TRISTATE register contents; 1 = pin driven.
REQ-011 rf_gpio_datareg  output  16  DATAREG register contents; pin output values.
REQ-012 rf_gpio_interrupt_mask  output  16  IMASK register contents; 1 = pin interrupt enabled.

Function
REQ-013 The register map SHALL be: addr 0 TRISTATE (RW); 1 DATAREG (RW); 2 PINSTATE (RO); 3 IMASK (RW); 4 ISTATUS (W1C); 5 ID (RO, 32'h4750_494F); 6 and 7 reserved.
REQ-014 All 16-bit registers SHALL occupy rdata/wdata bits 15:0, and rdata[31:16] SHALL read 0 for them.
REQ-015 A write SHALL occur on the rising edge when r_wn=0 and the addressed register is RW or W1C.
REQ-016 Within a write, wben[0] SHALL gate bits 7:0 and wben[1] SHALL gate bits 15:8; wben[3:2] SHALL be ignored.
REQ-017 A write with wben=0 SHALL change nothing.
REQ-018 Writes to PINSTATE, ID and the reserved slots SHALL be ignored without error.
REQ-019 Each RW register output (rf_*) SHALL reflect a write on the cycle after the write edge.
REQ-020 ro_gpio_pinstate SHALL pass through a 2-flop synchronizer; PINSTATE SHALL read the second flop stage.
REQ-021 A pin change SHALL reach PINSTATE 2 clocks after it is sampled.
REQ-022 An edge detector SHALL compare the second synchronizer stage with a third, delayed copy.
REQ-023 Any bit change in the synchronized pins SHALL set the matching ISTATUS bit, regardless of IMASK.
REQ-024 A write to ISTATUS SHALL clear each bit written as 1 within the enabled bytes; bits written as 0 SHALL be unaffected.
REQ-025 If a pin-change set and a W1C clear hit the same ISTATUS bit in the same cycle, the set SHALL win.
REQ-026 Reads SHALL have 1-cycle latency: rdata is registered and loads the addressed value on a rising edge with r_wn=1.
REQ-027 rdata SHALL hold its previous value while r_wn=0.
REQ-028 Reads of the reserved slots SHALL return 32'h0000_0000.
REQ-029 Reads SHALL have no side effects.
REQ-030 Reading ISTATUS SHALL NOT clear it.

Reset
REQ-031 While reset=0, the block SHALL immediately force to 0: TRISTATE, DATAREG, IMASK, ISTATUS, rdata, and all synchronizer and edge flops.
REQ-032 The first write or read SHALL be honoured on the first rising edge after reset deasserts.
REQ-033 Reset asserted mid-access SHALL abort the access; no partial update SHALL survive.
REQ-034 No ISTATUS bit SHALL be set by the deassertion of reset itself.
REQ-035 After reset, rf_gpio_tristate, rf_gpio_datareg and rf_gpio_interrupt_mask SHALL read 16'h0000.

Verification
REQ-036 Reset: hold reset=0 for 50 ns with random inputs -> all rf_* = 0 and rdata = 0.
REQ-037 Byte enables: write addr 1, wdata 32'hFFFF_A5C3, wben 4'b0001 -> rf_gpio_datareg = 16'h00C3; a following read of addr 1 -> rdata = 32'h0000_00C3.
REQ-038 Full write: write addr 0 with 16'h1234 and wben 4'b1111, write addr 3 with 16'h00FF -> rf_gpio_tristate = 16'h1234, rf_gpio_interrupt_mask = 16'h00FF; reads return the same values with upper bits 0.
REQ-039 Pin sync: ro_gpio_pinstate steps 0 -> 16'h8001 -> PINSTATE reads 16'h8001 two edges later, and ISTATUS reads 16'h8001.
REQ-040 W1C: write ISTATUS with 16'h0001 -> ISTATUS = 16'h8000; a simultaneous new change on bit 0 during the clear -> bit 0 stays 1.
REQ-041 Read-only and reserved slots: read addr 5 -> 32'h4750_494F; write addr 2, 5 and 6 -> no change; read addr 7 -> 0.
